ori_video_timing: RTL and testbench

ORI_VIDEO_TIMING -- requirements
Module: ori_video_timing

---
 rtl/ori_video_timing.sv | 168 ++++++++++++++++
 tb/tb_ori_video_timing.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ori_video_timing.sv
// Raster timing generator: pixel/line counters with registered sync, blank and strobe outputs.
// Every decoded output is computed from the next counter value, so it lines up with the counters.
module ori_video_timing #(
    parameter int HW        = 10,
    parameter int VW        = 9,
    parameter int H_ACTIVE  = 384,
    parameter int H_FP      = 87,
    parameter int H_SYNC    = 32,
    parameter int H_BP      = 137,
    parameter int V_ACTIVE  = 256,
    parameter int V_FP      = 28,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 24,
    parameter bit SYNC_POL  = 1'b0,
    parameter int BLANK_DLY = 1
) (
    input  logic          clk_i,
    input  logic          por_i,
    input  logic          cke_i,
    input  logic          run_i,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          hblank_o,
    output logic          vblank_o,
    output logic          blank_o,
    output logic          de_o,
    output logic          line_start_o,
    output logic          frame_start_o,
    output logic [7:0]    frame_cnt_o
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] HB_FIRST = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] VB_FIRST = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          SYNC_ON  = SYNC_POL;
    localparam logic          SYNC_OFF = ~SYNC_POL;

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_err_porch
            $error("ori_video_timing: every active/porch/sync length must be at least 1");
        end
        if (H_TOT > (1 << HW) || V_TOT > (1 << VW)) begin : g_err_width
            $error("ori_video_timing: counter width too small for the line/frame total");
        end
        if (BLANK_DLY < 0 || BLANK_DLY > 3) begin : g_err_dly
            $error("ori_video_timing: BLANK_DLY must be in 0..3");
        end
    endgenerate

    logic [HW-1:0]      r_h_cnt;
    logic [VW-1:0]      r_v_cnt;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_hblank;
    logic               r_vblank;
    logic               r_line_start;
    logic               r_frame_start;
    logic [7:0]         r_frame_cnt;
    logic [BLANK_DLY:0] r_blank_sr;

    logic [HW-1:0]      w_h_nxt;
    logic [VW-1:0]      w_v_nxt;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_hs_act;
    logic               w_vs_act;
    logic               w_hb_nxt;
    logic               w_vb_nxt;
    logic [BLANK_DLY:0] w_blank_sr_nxt;

    // Next counter values and their decodes.
    always_comb begin
        w_h_wrap = (r_h_cnt == H_LAST);
        w_v_wrap = (r_v_cnt == V_LAST);
        w_h_nxt  = r_h_cnt;
        w_v_nxt  = r_v_cnt;
        if (w_h_wrap) begin
            w_h_nxt = '0;
            if (w_v_wrap) begin
                w_v_nxt = '0;
            end else begin
                w_v_nxt = r_v_cnt + VW'(1);
            end
        end else begin
            w_h_nxt = r_h_cnt + HW'(1);
        end
        w_hs_act = (w_h_nxt >= HS_FIRST) && (w_h_nxt <= HS_LAST);
        w_vs_act = (w_v_nxt >= VS_FIRST) && (w_v_nxt <= VS_LAST);
        w_hb_nxt = (w_h_nxt >= HB_FIRST);
        w_vb_nxt = (w_v_nxt >= VB_FIRST);
    end

    // Stage 0 carries the undelayed blank; higher stages add one cke tick each.
    generate
        if (BLANK_DLY == 0) begin : g_sr0
            assign w_blank_sr_nxt = w_hb_nxt | w_vb_nxt;
        end else begin : g_srn
            assign w_blank_sr_nxt = {r_blank_sr[BLANK_DLY-1:0], w_hb_nxt | w_vb_nxt};
        end
    endgenerate

    // Timing state: parking at (0,0) looks like reset except that the frame count is kept.
    always_ff @(posedge clk_i or posedge por_i) begin
        if (por_i) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= SYNC_OFF;
            r_vsync       <= SYNC_OFF;
            r_hblank      <= 1'b0;
            r_vblank      <= 1'b0;
            r_blank_sr    <= '1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= 8'd0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (cke_i) begin
                if (!run_i) begin
                    r_h_cnt    <= '0;
                    r_v_cnt    <= '0;
                    r_hsync    <= SYNC_OFF;
                    r_vsync    <= SYNC_OFF;
                    r_hblank   <= 1'b0;
                    r_vblank   <= 1'b0;
                    r_blank_sr <= '1;
                end else begin
                    r_h_cnt       <= w_h_nxt;
                    r_v_cnt       <= w_v_nxt;
                    r_hsync       <= w_hs_act ? SYNC_ON : SYNC_OFF;
                    r_vsync       <= w_vs_act ? SYNC_ON : SYNC_OFF;
                    r_hblank      <= w_hb_nxt;
                    r_vblank      <= w_vb_nxt;
                    r_blank_sr    <= w_blank_sr_nxt;
                    r_line_start  <= w_h_wrap;
                    r_frame_start <= w_h_wrap & w_v_wrap;
                    if (w_h_wrap && w_v_wrap) begin
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign h_cnt_o       = r_h_cnt;
    assign v_cnt_o       = r_v_cnt;
    assign hsync_o       = r_hsync;
    assign vsync_o       = r_vsync;
    assign hblank_o      = r_hblank;
    assign vblank_o      = r_vblank;
    assign blank_o       = r_blank_sr[BLANK_DLY];
    assign de_o          = ~r_blank_sr[BLANK_DLY];
    assign line_start_o  = r_line_start;
    assign frame_start_o = r_frame_start;
    assign frame_cnt_o   = r_frame_cnt;

endmodule

// File: tb/tb_ori_video_timing.sv
// Directed bench: a tiny 11x5 raster (active-high syncs, 1-tick blank delay) plus the
// default 640-pixel raster (3-tick blank delay), driven from shared inputs.
module tb_ori_video_timing;

    logic clk = 1'b0;
    logic por = 1'b1;
    logic cke = 1'b1;
    logic run = 1'b1;

    always #5 clk = ~clk;

    logic [3:0] s_h;
    logic [2:0] s_v;
    logic       s_hs, s_vs, s_hb, s_vb, s_bl, s_de, s_ls, s_fs;
    logic [7:0] s_fc;

    logic [9:0] d_h;
    logic [8:0] d_v;
    logic       d_hs, d_vs, d_hb, d_vb, d_bl, d_de, d_ls, d_fs;
    logic [7:0] d_fc;

    ori_video_timing #(
        .HW(4), .VW(3),
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .BLANK_DLY(1)
    ) dut_s (
        .clk_i(clk), .por_i(por), .cke_i(cke), .run_i(run),
        .h_cnt_o(s_h), .v_cnt_o(s_v), .hsync_o(s_hs), .vsync_o(s_vs),
        .hblank_o(s_hb), .vblank_o(s_vb), .blank_o(s_bl), .de_o(s_de),
        .line_start_o(s_ls), .frame_start_o(s_fs), .frame_cnt_o(s_fc)
    );

    ori_video_timing #(.BLANK_DLY(3)) dut_d (
        .clk_i(clk), .por_i(por), .cke_i(cke), .run_i(run),
        .h_cnt_o(d_h), .v_cnt_o(d_v), .hsync_o(d_hs), .vsync_o(d_vs),
        .hblank_o(d_hb), .vblank_o(d_vb), .blank_o(d_bl), .de_o(d_de),
        .line_start_o(d_ls), .frame_start_o(d_fs), .frame_cnt_o(d_fc)
    );

    typedef struct {
        int tick; int h; int v;
        int hs; int vs; int hb; int vb; int bl; int ls; int fs; int fc;
    } vec_t;

    vec_t tbl [15];

    int t = 0;
    int checks = 0;
    int failures = 0;
    int de_bad = 0;
    bit mon_en = 1'b0;
    int hs_low = 0, hs_first = -1, hb_rise = -1, bl_rise = -1;
    int ls_first = -1, ls_second = -1;
    logic prev_bl_d = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
        if (s_de !== ~s_bl) de_bad++;
        if (d_de !== ~d_bl) de_bad++;
        if (mon_en) begin
            if (d_hs == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(d_h);
            end
            if (d_hb && hb_rise < 0) hb_rise = t;
            if (d_bl && !prev_bl_d && bl_rise < 0) bl_rise = t;
            if (d_ls) begin
                if (ls_first < 0) ls_first = t;
                else if (ls_second < 0) ls_second = t;
            end
        end
        prev_bl_d = d_bl;
    endtask

    task automatic do_reset();
        por = 1'b1;
        cke = 1'b1;
        run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        por = 1'b0;
        t = 0;
    endtask

    int first_c, second_c, dbl, ls_cnt, strobes;
    logic prev_ls;

    initial begin
        //         tick  h  v hs vs hb vb bl ls fs fc
        tbl[0]  = '{ 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[1]  = '{ 1,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{ 2,  2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{ 8,  8, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{ 9,  9, 0, 1, 0, 1, 0, 1, 0, 0, 0};
        tbl[5]  = '{10, 10, 0, 0, 0, 1, 0, 1, 0, 0, 0};
        tbl[6]  = '{11,  0, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        tbl[7]  = '{12,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{22,  0, 2, 0, 0, 0, 1, 1, 1, 0, 0};
        tbl[9]  = '{23,  1, 2, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[10] = '{33,  0, 3, 0, 1, 0, 1, 1, 1, 0, 0};
        tbl[11] = '{42,  9, 3, 1, 1, 1, 1, 1, 0, 0, 0};
        tbl[12] = '{44,  0, 4, 0, 0, 0, 1, 1, 1, 0, 0};
        tbl[13] = '{55,  0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        tbl[14] = '{56,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1};

        // values held while por is asserted
        repeat (3) @(posedge clk);
        #1;
        chk("rst_h", int'(s_h), 0);
        chk("rst_v", int'(s_v), 0);
        chk("rst_fc", int'(s_fc), 0);
        chk("rst_hsync_s", int'(s_hs), 0);
        chk("rst_vsync_d", int'(d_vs), 1);
        chk("rst_hsync_d", int'(d_hs), 1);
        chk("rst_hblank", int'(s_hb), 0);
        chk("rst_blank", int'(s_bl), 1);
        chk("rst_de", int'(d_de), 0);
        chk("rst_ls", int'(s_ls), 0);
        por = 1'b0;
        t = 0;
        mon_en = 1'b1;

        for (int i = 0; i < 15; i++) begin
            while (t < tbl[i].tick) tick();
            chk($sformatf("row%0d_h", i), int'(s_h), tbl[i].h);
            chk($sformatf("row%0d_v", i), int'(s_v), tbl[i].v);
            chk($sformatf("row%0d_hsync", i), int'(s_hs), tbl[i].hs);
            chk($sformatf("row%0d_vsync", i), int'(s_vs), tbl[i].vs);
            chk($sformatf("row%0d_hblank", i), int'(s_hb), tbl[i].hb);
            chk($sformatf("row%0d_vblank", i), int'(s_vb), tbl[i].vb);
            chk($sformatf("row%0d_blank", i), int'(s_bl), tbl[i].bl);
            chk($sformatf("row%0d_de", i), int'(s_de), 1 - tbl[i].bl);
            chk($sformatf("row%0d_ls", i), int'(s_ls), tbl[i].ls);
            chk($sformatf("row%0d_fs", i), int'(s_fs), tbl[i].fs);
            chk($sformatf("row%0d_fc", i), int'(s_fc), tbl[i].fc);
        end

        // default raster: two full lines
        while (t < 1300) tick();
        mon_en = 1'b0;
        chk("d_hsync_first_h", hs_first, 471);
        chk("d_hsync_low_clks", hs_low, 64);
        chk("d_hblank_rise", hb_rise, 384);
        chk("d_blank_rise_dly3", bl_rise, 387);
        chk("d_line_start_first", ls_first, 640);
        chk("d_line_period", ls_second - ls_first, 640);
        chk("d_v_after_2_lines", int'(d_v), 2);

        // cke toggling 1/0 doubles the line period
        do_reset();
        first_c = -1; second_c = -1; dbl = 0; ls_cnt = 0; prev_ls = 1'b0;
        while (t < 80) begin
            tick();
            if (s_ls) begin
                ls_cnt++;
                if (prev_ls) dbl++;
                if (first_c < 0) first_c = t;
                else if (second_c < 0) second_c = t;
            end
            if (t == 22) chk("cke_freeze_h", int'(s_h), 0);
            prev_ls = s_ls;
            cke = ~cke;
        end
        cke = 1'b1;
        chk("cke_ls_first", first_c, 21);
        chk("cke_line_period", second_c - first_c, 22);
        chk("cke_ls_width", dbl, 0);
        chk("cke_ls_count", ls_cnt, 3);

        // freeze, park mid-line, resume
        do_reset();
        while (t < 71) tick();
        chk("pre_park_h", int'(s_h), 5);
        chk("pre_park_v", int'(s_v), 1);
        chk("pre_park_fc", int'(s_fc), 1);
        cke = 1'b0;
        repeat (5) tick();
        chk("freeze_h", int'(s_h), 5);
        chk("freeze_v", int'(s_v), 1);
        chk("freeze_d_h", int'(d_h), 71);
        cke = 1'b1;
        run = 1'b0;
        tick();
        chk("park_h", int'(s_h), 0);
        chk("park_v", int'(s_v), 0);
        chk("park_hsync", int'(s_hs), 0);
        chk("park_blank", int'(s_bl), 1);
        chk("park_de", int'(s_de), 0);
        chk("park_fc", int'(s_fc), 1);
        chk("park_d_h", int'(d_h), 0);
        chk("park_d_hsync", int'(d_hs), 1);
        strobes = 0;
        repeat (9) begin
            tick();
            if (s_ls || s_fs || d_ls || d_fs) strobes++;
        end
        run = 1'b1;
        tick();
        if (s_ls || s_fs || d_ls || d_fs) strobes++;
        chk("resume_h", int'(s_h), 1);
        chk("resume_v", int'(s_v), 0);
        chk("resume_fc", int'(s_fc), 1);
        chk("resume_d_h", int'(d_h), 1);
        chk("park_strobes", strobes, 0);
        tick();
        chk("resume_h2", int'(s_h), 2);

        // 256 frames: frame counter wraps with frame_start on the v wrap
        do_reset();
        while (t < 255 * 55) tick();
        chk("f255_fc", int'(s_fc), 255);
        chk("f255_fs", int'(s_fs), 1);
        while (t < 256 * 55) tick();
        chk("f256_fc", int'(s_fc), 0);
        chk("f256_fs", int'(s_fs), 1);
        chk("f256_h", int'(s_h), 0);
        chk("f256_v", int'(s_v), 0);
        tick();
        chk("f256_fs_width", int'(s_fs), 0);
        while (t < 256 * 55 + 61) tick();
        chk("pre_por_h", int'(s_h), 6);
        chk("pre_por_fc", int'(s_fc), 1);

        // asynchronous por mid-line
        #1;
        por = 1'b1;
        #1;
        chk("apor_h", int'(s_h), 0);
        chk("apor_fc", int'(s_fc), 0);
        chk("apor_blank", int'(s_bl), 1);
        chk("apor_d_h", int'(d_h), 0);
        chk("apor_d_hsync", int'(d_hs), 1);
        @(posedge clk);
        #1;
        por = 1'b0;
        t = 0;
        tick();
        chk("apor_resume_h", int'(s_h), 1);
        chk("apor_resume_ls", int'(s_ls), 0);

        chk("de_inverse_blank", de_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
